// File: rtl/div_pkg.sv
// div_pkg: shared widths, FSM state type and full-adder cell for the div25x9_seq divider.
package div_pkg;
  localparam int MD_WD = 16;
  localparam int MR_WD = 9;
  localparam int MDMR_WD = MD_WD + MR_WD;
  localparam int CNT_WD = $clog2(MD_WD);
  localparam logic [CNT_WD-1:0] CNT_LAST = CNT_WD'(MD_WD - 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_e;
  function automatic logic [1:0] fa(input logic a, input logic b, input logic ci);
    return {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
  endfunction
endpackage

// File: rtl/restore_step.sv
// restore_step: one restoring-division iteration; the subtractor's carry-out doubles as the T >= divisor compare.
module restore_step
  import div_pkg::*;
(
  input  logic [MR_WD-1:0] r_i,
  input  logic             bit_i,
  input  logic [MR_WD-1:0] divisor_i,
  output logic [MR_WD-1:0] r_o,
  output logic             q_o
);
  logic [MR_WD:0]   t;
  logic [MR_WD:0]   c;
  logic [MR_WD-1:0] diff;
  assign t    = {r_i, bit_i};
  assign c[0] = 1'b1;
  for (genvar g = 0; g < MR_WD; g++) begin : g_fa
    assign {c[g+1], diff[g]} = fa(t[g], ~divisor_i[g], c[g]);
  end
  // Top cell subtracts the divisor's implicit zero MSB, so only its carry matters.
  assign q_o = t[MR_WD] | c[MR_WD];
  assign r_o = q_o ? diff : t[MR_WD-1:0];
endmodule

// File: rtl/div25x9_seq.sv
// div25x9_seq: sequential 25/9 restoring divider, one quotient bit per clock.
// DIV25X9_ERR_CHECK_EN enables div_zero/overflow detection with a one-cycle fast path.
module div25x9_seq
  import div_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MDMR_WD-1:0] dividend,
  input  logic [MR_WD-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MD_WD-1:0]   quotient,
  output logic [MR_WD-1:0]   remainder,
  output logic               div_zero,
  output logic               overflow
);
  div_state_e        state_q, state_d;
  logic [CNT_WD-1:0] cnt_q, cnt_d;
  logic [MD_WD-1:0]  dvd_q, dvd_d, quo_q, quo_d;
  logic [MR_WD-1:0]  dvs_q, dvs_d, rem_q, rem_d, step_r;
  logic              out_valid_q, out_valid_d, dz_q, dz_d, ov_q, ov_d;
  logic              step_bit, err_dz, err_ov, err_q;
  restore_step u_step (
    .r_i      (rem_q),
    .bit_i    (dvd_q[MD_WD-1]),
    .divisor_i(dvs_q),
    .r_o      (step_r),
    .q_o      (step_bit)
  );
`ifdef DIV25X9_ERR_CHECK_EN
  assign err_dz = divisor == '0;
  assign err_ov = !err_dz && (dividend[MDMR_WD-1:MD_WD] >= divisor);
`else
  assign err_dz = 1'b0;
  assign err_ov = 1'b0;
`endif
  assign err_q = dz_q | ov_q;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    out_valid_d = out_valid_q;
    dz_d        = dz_q;
    ov_d        = ov_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = CALC;
        cnt_d   = CNT_LAST;
        dvd_d   = dividend[MD_WD-1:0];
        dvs_d   = divisor;
        dz_d    = err_dz;
        ov_d    = err_ov;
        quo_d   = (err_dz || err_ov) ? '1 : '0;
        rem_d   = err_dz ? dividend[MR_WD-1:0] : err_ov ? '0 : dividend[MDMR_WD-1:MD_WD];
      end
      // Error results are already loaded at acceptance; CALC just spends one cycle and exits.
      CALC: begin
        state_d     = (err_q || cnt_q == '0) ? DONE : CALC;
        out_valid_d = state_d == DONE;
        if (!err_q) begin
          cnt_d = cnt_q - 1'b1;
          dvd_d = dvd_q << 1;
          quo_d = {quo_q[MD_WD-2:0], step_bit};
          rem_d = step_r;
        end
      end
      DONE: if (out_ready) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        dz_d        = 1'b0;
        ov_d        = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      dz_q        <= 1'b0;
      ov_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
      dz_q        <= dz_d;
      ov_q        <= ov_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = out_valid_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;
  assign overflow  = ov_q;
endmodule

// File: tb/tb_div25x9_seq.sv
// tb_div25x9_seq: scoreboard bench for div25x9_seq with an arithmetic reference model.
module tb_div25x9_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [24:0] dividend = '0;
  logic [8:0]  divisor = '0;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [8:0]  remainder;
  logic        div_zero;
  logic        overflow;

  typedef struct {
    logic [15:0] q;
    logic [8:0]  r;
    logic        dz;
    logic        ov;
    int          done;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   bp_mode = 0;
  bit   seen = 0;

  div25x9_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dividend (dividend),
    .divisor  (divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero),
    .overflow (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [24:0] a, input logic [8:0] b, input int now);
    exp_t e;
    e.dz = 1'b0;
    e.ov = 1'b0;
    e.done = now + 16;
`ifdef DIV25X9_ERR_CHECK_EN
    if (b == 0) begin
      e.dz = 1'b1; e.q = 16'hFFFF; e.r = 9'(a % 512); e.done = now + 1;
      return e;
    end
    if ((a / 65536) >= b) begin
      e.ov = 1'b1; e.q = 16'hFFFF; e.r = 9'd0; e.done = now + 1;
      return e;
    end
`endif
    e.q = 16'(int'(a) / int'(b));
    e.r = 9'(int'(a) % int'(b));
    return e;
  endfunction

  task automatic issue(input logic [24:0] a, input logic [8:0] b);
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("issue_ready_timeout", 32'(w >= 200), 0);
    if (w >= 200) return;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(model(a, b, cyc));
    in_valid = 1'b0;
    dividend = 25'($urandom);
    divisor  = 9'($urandom);
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk("drain_timeout", 32'(sb.size()), 0);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = bp_mode == 0 ? 1'b1 : bp_mode == 1 ? 1'($urandom_range(0, 2) != 0) : 1'b0;
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) seen = 0;
      else if (out_valid) begin
        if (sb.size() == 0) chk("unexpected_out_valid", 32'(out_valid), 0);
        else begin
          if (!seen) begin
            chk("latency", cyc, sb[0].done);
            seen = 1;
          end
          if (out_ready) begin
            e = sb.pop_front();
            chk("quotient", 32'(quotient), 32'(e.q));
            chk("remainder", 32'(remainder), 32'(e.r));
            chk("div_zero", 32'(div_zero), 32'(e.dz));
            chk("overflow", 32'(overflow), 32'(e.ov));
            seen = 0;
          end
        end
      end
    end
  end

  initial begin : main
    logic [24:0] a;
    logic [8:0]  b;
    int          w;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_quotient", 32'(quotient), 0);
    chk("rst_remainder", 32'(remainder), 0);
    chk("rst_flags", {30'd0, div_zero, overflow}, 0);

    issue(25'd1000, 9'd7);
    drain();
    issue(25'd33488895, 9'd511);
    drain();
`ifdef DIV25X9_ERR_CHECK_EN
    issue(25'd12345, 9'd0);
    drain();
    issue(25'h1FFFFFF, 9'd3);
    drain();
`endif

    // Backpressure: result held, new operands refused while DONE.
    bp_mode = 2;
    issue(25'd1000, 9'd7);
    w = 0;
    while (!out_valid && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("bp_wait_valid", 32'(out_valid), 1);
    in_valid = 1'b1;
    dividend = 25'd12345;
    divisor  = 9'd3;
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_quotient", 32'(quotient), 142);
      chk("bp_remainder", 32'(remainder), 6);
      chk("bp_in_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0;
    bp_mode = 0;
    @(negedge clk);
    chk("bp_transfer_pending", 32'({out_valid, out_ready}), 3);
    @(negedge clk);
    chk("bp_idle_in_ready", 32'(in_ready), 1);
    chk("bp_idle_out_valid", 32'(out_valid), 0);
    repeat (2) @(negedge clk);
    chk("bp_no_accept", 32'(in_ready), 1);
    chk("bp_queue_empty", 32'(sb.size()), 0);

    // Reset in the middle of CALC discards the operation.
    issue(25'd1000, 9'd7);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_quotient", 32'(quotient), 0);
    chk("midrst_remainder", 32'(remainder), 0);
    chk("midrst_flags", {30'd0, div_zero, overflow}, 0);
    sb.delete();
    rst_n = 1'b1;
    issue(25'd1000, 9'd7);
    drain();

    // Randomised legal operands under random backpressure.
    bp_mode = 1;
    repeat (40) begin
      b = 9'($urandom_range(1, 511));
      a = 25'(32'($urandom_range(0, 65535)) * 32'(b) + 32'($urandom_range(0, int'(b) - 1)));
      issue(a, b);
    end
`ifdef DIV25X9_ERR_CHECK_EN
    repeat (12) begin
      b = ($urandom_range(0, 1) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
      a = {9'($urandom_range(int'(b), 511)), 16'($urandom)};
      issue(a, b);
    end
`endif
    drain();
    bp_mode = 0;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/div25x9_seq.md
# div25x9_seq

Sequential restoring divider: the inverse of the 16x9 multiplier datapath. Divides a 25-bit dividend by a 9-bit divisor and returns a 16-bit quotient and a 9-bit remainder, one quotient bit per clock. Used to check or undo multiplier products. Valid/ready handshakes on both sides; one operation in flight.

## Interface
- MD_WD, 16: quotient width (multiplicand side).
- MR_WD, 9: divisor and remainder width.
- MDMR_WD, MD_WD+MR_WD: dividend width.
- clk  in  1  single clock; all flops on the rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- in_valid  in  1  operands valid.
- in_ready  out  1  block idle and can accept; equals (state==IDLE).
- dividend  in  MDMR_WD  numerator, unsigned.
- divisor  in  MR_WD  denominator, unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- quotient  out  MD_WD  result quotient.
- remainder  out  MR_WD  result remainder.
- div_zero  out  1  divisor was 0.
- overflow  out  1  quotient would not fit in MD_WD bits.

## Operation
- FSM states: IDLE, CALC, DONE. Reset state is IDLE.
- IDLE: in_valid&&in_ready latches the operands and clears the step counter to MD_WD-1.
  - If the error check flags an error, go to DONE.
  - Otherwise go to CALC with partial remainder R (MR_WD+1 bits) = {0, dividend[MDMR_WD-1:MD_WD]}.
- CALC, for each step i = MD_WD-1 down to 0:
  - T = {R[MR_WD-1:0], dividend[i]}.
  - If T >= {0,divisor}: R = T - divisor and q[i] = 1. Otherwise R = T and q[i] = 0.
  - After step i==0, go to DONE.
- Legal operands guarantee R < divisor, so R fits in MR_WD bits. remainder = R[MR_WD-1:0].
- DONE: out_valid=1 and all outputs held stable. out_valid&&out_ready returns to IDLE. Flags clear on that transfer.
- While not IDLE, in_valid is ignored and operands are not sampled.
- Error cases (only with the macro enabled):
  - divisor==0: div_zero=1, quotient='1, remainder=dividend[MR_WD-1:0].
  - divisor!=0 and dividend[MDMR_WD-1:MD_WD] >= divisor: overflow=1, quotient='1, remainder=0.
  - div_zero takes priority; overflow stays 0 when div_zero is set.

## Timing
- Reset values: out_valid=0, quotient=0, remainder=0, div_zero=0, overflow=0. in_ready=1 from the first cycle after reset.
- Edge numbering: accepting edge is E0.
  - Normal operation: CALC steps run on E1..E16, and out_valid is high after E16 (latency 16 cycles).
  - Error fast path: out_valid is high after E1.
- Earliest next acceptance is one edge after the output transfer edge, so normal throughput is 1 per 18 cycles with out_ready tied high.
- rst_n low on any edge forces IDLE and the reset values regardless of state. An in-flight operation is discarded with no partial output.

## Configuration
- DIV25X9_ERR_CHECK_EN defined: div_zero/overflow detection and the one-cycle fast path, as described above.
- Not defined:
  - div_zero and overflow are tied 0.
  - Every operand pair runs the full 16 CALC steps.
  - Illegal operands give the deterministic raw restoring-algorithm output, which is not meaningful.
  - Latency is always 16.

## Structure
- Shared package div_pkg holds:
  - MD_WD, MR_WD, MDMR_WD defaults;
  - the state enum typedef div_state_e {IDLE, CALC, DONE}.
- Sub-module restore_step (combinational, one restoring iteration):
  - inputs: R, next dividend bit, divisor;
  - outputs: next R, quotient bit;
  - subtraction is a ripple chain of fulladder cells, using the borrow-out as the compare.
- Top level holds the FSM, counter, operand/quotient shift registers and handshakes.

## Test plan
- dividend=1000, divisor=7 → quotient=142, remainder=6, out_valid first high after E16, flags 0.
- dividend=33488895, divisor=511 → quotient=65535, remainder=510, no overflow.
- (EN) dividend=12345, divisor=0 → div_zero=1, quotient=16'hFFFF, remainder=57, out_valid after E1.
- (EN) dividend=25'h1FFFFFF, divisor=3 → overflow=1, quotient=16'hFFFF, remainder=0, out_valid after E1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, while driving in_valid with new operands.
  - Outputs stay stable, in_ready stays 0, and the new operands are not taken.
  - After out_ready=1, IDLE and in_ready=1 on the next cycle.
- Reset mid-CALC: rst_n=0 at E8 → next cycle IDLE with out_valid=0 and all outputs 0. The next operation, 1000/7, completes correctly.
